// File: rtl/ex_mem_ctrl_reg_pkg.sv
// ex_mem_ctrl_reg_pkg: shared pipeline constants and the stage-action decode
package ex_mem_ctrl_reg_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic [7:0]  EXE_NOP_OP   = 8'b00000000;

    typedef enum logic [1:0] {
        ACT_KILL,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } act_e;

    // Reset and flush both force the NOP image; the illegal src=0/dst=1 stall pattern falls into advance
    function automatic act_e decode_act(input logic rst_n, input logic flush,
                                        input logic src_stall, input logic dst_stall);
        return (rst_n == RstEnable || flush)             ? ACT_KILL    :
               (src_stall == Stop && dst_stall != Stop)  ? ACT_BUBBLE  :
               (src_stall != Stop)                       ? ACT_ADVANCE : ACT_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_ctrl_reg_if.sv
// ex_mem_ctrl_reg_if: EX/MEM stage payload bundle
interface ex_mem_ctrl_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8
);
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;

    modport master (output wd, wreg, wdata, whilo, hi, lo, aluop, mem_addr, reg2);
    modport slave  (input  wd, wreg, wdata, whilo, hi, lo, aluop, mem_addr, reg2);
endinterface

// File: rtl/ex_mem_ctrl_reg_sat_counter.sv
// sat_counter: saturating event counter with synchronous active-low reset
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_d, count_q;

    // Increment until all-ones, then stick
    always_comb count_d = !Rst_n ? '0 : (inc && count_q != '1) ? count_q + WIDTH'(1) : count_q;

    // Counter register
    always_ff @(posedge clk) count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/ex_mem_ctrl_reg.sv
// ex_mem_ctrl_reg: EX->MEM pipeline register with stall, flush, bubble and accumulate loop-back
module ex_mem_ctrl_reg
    import ex_mem_ctrl_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int CNT_W      = 2,
    parameter int STALL_W    = 6,
    parameter int SRC_IDX    = 3,
    parameter int DST_IDX    = 4,
    parameter int BUB_W      = 16
) (
    input  logic                clk,
    input  logic                Rst_n,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    ex_mem_ctrl_reg_if.slave    ex,
    ex_mem_ctrl_reg_if.master   mem,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [BUB_W-1:0]    bubble_cnt
);
    act_e                  act;
    logic [REG_ADDR_W-1:0] wd_d, wd_q;
    logic                  wreg_d, wreg_q, whilo_d, whilo_q;
    logic [DATA_W-1:0]     wdata_d, wdata_q, hi_d, hi_q, lo_d, lo_q;
    logic [DATA_W-1:0]     mem_addr_d, mem_addr_q, reg2_d, reg2_q;
    logic [ALUOP_W-1:0]    aluop_d, aluop_q;
    logic [2*DATA_W-1:0]   hilo_temp_d, hilo_temp_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;

    assign act = decode_act(Rst_n, flush, stall[SRC_IDX], stall[DST_IDX]);

    // Next-state select: kill/bubble load the NOP image, advance loads EX, hold keeps everything
    always_comb begin
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        whilo_d     = whilo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        aluop_d     = aluop_q;
        mem_addr_d  = mem_addr_q;
        reg2_d      = reg2_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        if (act == ACT_KILL || act == ACT_BUBBLE) begin
            wd_d        = REG_ADDR_W'(NOPRegAddr);
            wreg_d      = WriteDisable;
            wdata_d     = DATA_W'(ZeroWord);
            whilo_d     = WriteDisable;
            hi_d        = DATA_W'(ZeroWord);
            lo_d        = DATA_W'(ZeroWord);
            aluop_d     = ALUOP_W'(EXE_NOP_OP);
            mem_addr_d  = DATA_W'(ZeroWord);
            reg2_d      = DATA_W'(ZeroWord);
            hilo_temp_d = (act == ACT_BUBBLE) ? hilo_temp_i : '0;
            cnt_d       = (act == ACT_BUBBLE) ? cnt_i : '0;
        end else if (act == ACT_ADVANCE) begin
            wd_d        = ex.wd;
            wreg_d      = ex.wreg;
            wdata_d     = ex.wdata;
            whilo_d     = ex.whilo;
            hi_d        = ex.hi;
            lo_d        = ex.lo;
            aluop_d     = ex.aluop;
            mem_addr_d  = ex.mem_addr;
            reg2_d      = ex.reg2;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        wd_q        <= wd_d;
        wreg_q      <= wreg_d;
        wdata_q     <= wdata_d;
        whilo_q     <= whilo_d;
        hi_q        <= hi_d;
        lo_q        <= lo_d;
        aluop_q     <= aluop_d;
        mem_addr_q  <= mem_addr_d;
        reg2_q      <= reg2_d;
        hilo_temp_q <= hilo_temp_d;
        cnt_q       <= cnt_d;
    end

    sat_counter #(.WIDTH(BUB_W)) u_bubble_cnt (
        .clk   (clk),
        .Rst_n (Rst_n),
        .inc   (act == ACT_BUBBLE),
        .count (bubble_cnt)
    );

    assign mem.wd       = wd_q;
    assign mem.wreg     = wreg_q;
    assign mem.wdata    = wdata_q;
    assign mem.whilo    = whilo_q;
    assign mem.hi       = hi_q;
    assign mem.lo       = lo_q;
    assign mem.aluop    = aluop_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.reg2     = reg2_q;
    assign hilo_temp_o  = hilo_temp_q;
    assign cnt_o        = cnt_q;
endmodule

// File: tb/tb_ex_mem_ctrl_reg.sv
// tb_ex_mem_ctrl_reg: directed self-checking bench for the EX->MEM stage register
module tb_ex_mem_ctrl_reg;
    logic        clk = 1'b0;
    logic        Rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [63:0] hilo_temp_i, hilo_temp_o, hilo_temp_o2;
    logic [1:0]  cnt_i, cnt_o, cnt_o2;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_small;
    int          checks = 0;
    int          errors = 0;

    ex_mem_ctrl_reg_if ex_if ();
    ex_mem_ctrl_reg_if mem_if ();
    ex_mem_ctrl_reg_if mem2_if ();

    ex_mem_ctrl_reg dut (
        .clk(clk), .Rst_n(Rst_n), .stall(stall), .flush(flush),
        .ex(ex_if), .mem(mem_if),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    ex_mem_ctrl_reg #(.BUB_W(2)) dut_sat (
        .clk(clk), .Rst_n(Rst_n), .stall(stall), .flush(flush),
        .ex(ex_if), .mem(mem2_if),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .hilo_temp_o(hilo_temp_o2), .cnt_o(cnt_o2), .bubble_cnt(bubble_small)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (Rst_n && !stall[3] && stall[4]) begin
            errors++;
            $display("FAIL illegal_stall: stall=%b (src=0,dst=1) must never be driven", stall);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ex_if.wd = wd;
        ex_if.wreg = wreg;
        ex_if.wdata = wdata;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        stall = '0;
        flush = 1'b0;
        hilo_temp_i = 64'h1;
        cnt_i = 2'd2;
        set_ex(5'd7, 1'b1, 32'h12345678);
        ex_if.whilo = 1'b1;
        ex_if.hi = 32'h11;
        ex_if.lo = 32'h22;
        ex_if.aluop = 8'h55;
        ex_if.mem_addr = 32'h100;
        ex_if.reg2 = 32'h200;
        tick();
        tick();
        checks++; if (mem_if.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_if.wdata); end
        checks++; if (mem_if.wreg !== 1'b0 || mem_if.whilo !== 1'b0) begin errors++; $display("FAIL reset_we: got wreg=%b whilo=%b want 0/0", mem_if.wreg, mem_if.whilo); end
        checks++; if (mem_if.wd !== 5'd0 || mem_if.aluop !== 8'h00) begin errors++; $display("FAIL reset_nop: got wd=%h aluop=%h want 0/0", mem_if.wd, mem_if.aluop); end
        checks++; if (mem_if.hi !== 32'h0 || mem_if.lo !== 32'h0 || mem_if.mem_addr !== 32'h0 || mem_if.reg2 !== 32'h0) begin errors++; $display("FAIL reset_data: got hi=%h lo=%h addr=%h reg2=%h want 0", mem_if.hi, mem_if.lo, mem_if.mem_addr, mem_if.reg2); end
        checks++; if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_acc: got hilo=%h cnt=%0d bub=%0d want 0", hilo_temp_o, cnt_o, bubble_cnt); end
        Rst_n = 1'b1;
        tick();
        checks++; if (mem_if.wdata !== 32'h12345678 || mem_if.wreg !== 1'b1 || mem_if.wd !== 5'd7) begin errors++; $display("FAIL reset_release: got wd=%0d wreg=%b wdata=%h want 7/1/12345678", mem_if.wd, mem_if.wreg, mem_if.wdata); end
        checks++; if (mem_if.aluop !== 8'h55 || mem_if.mem_addr !== 32'h100 || mem_if.reg2 !== 32'h200) begin errors++; $display("FAIL advance_fields: got aluop=%h addr=%h reg2=%h want 55/100/200", mem_if.aluop, mem_if.mem_addr, mem_if.reg2); end
    endtask

    task automatic test_hold();
        set_ex(5'd5, 1'b1, 32'hA5A5A5A5);
        tick();
        checks++; if (mem_if.wd !== 5'd5 || mem_if.wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL hold_load: got wd=%0d wdata=%h want 5/a5a5a5a5", mem_if.wd, mem_if.wdata); end
        stall = 6'b011111;
        hilo_temp_i = 64'hFFFF;
        cnt_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(9 + i), 1'b0, 32'h1111 * (i + 1));
            tick();
            checks++; if (mem_if.wd !== 5'd5 || mem_if.wdata !== 32'hA5A5A5A5 || mem_if.wreg !== 1'b1) begin errors++; $display("FAIL hold_cycle%0d: got wd=%0d wreg=%b wdata=%h want 5/1/a5a5a5a5", i, mem_if.wd, mem_if.wreg, mem_if.wdata); end
            checks++; if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL hold_acc%0d: got hilo=%h cnt=%0d bub=%0d want 0/0/0", i, hilo_temp_o, cnt_o, bubble_cnt); end
        end
        stall = '0;
    endtask

    task automatic test_bubble();
        set_ex(5'd3, 1'b1, 32'hCAFEF00D);
        stall = 6'b001111;
        hilo_temp_i = 64'h0000_0001_FFFF_FFFE;
        cnt_i = 2'd1;
        tick();
        checks++; if (mem_if.wreg !== 1'b0 || mem_if.wdata !== 32'h0 || mem_if.aluop !== 8'h00) begin errors++; $display("FAIL bubble_nop: got wreg=%b wdata=%h aluop=%h want 0/0/0", mem_if.wreg, mem_if.wdata, mem_if.aluop); end
        checks++; if (hilo_temp_o !== 64'h0000_0001_FFFF_FFFE || cnt_o !== 2'd1) begin errors++; $display("FAIL bubble_acc: got hilo=%h cnt=%0d want 00000001fffffffe/1", hilo_temp_o, cnt_o); end
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL bubble_cnt: got %0d want 1", bubble_cnt); end
        stall = '0;
        tick();
        checks++; if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0) begin errors++; $display("FAIL bubble_release_acc: got hilo=%h cnt=%0d want 0/0", hilo_temp_o, cnt_o); end
        checks++; if (mem_if.wreg !== 1'b1 || mem_if.wdata !== 32'hCAFEF00D || bubble_cnt !== 16'd1) begin errors++; $display("FAIL bubble_release: got wreg=%b wdata=%h bub=%0d want 1/cafef00d/1", mem_if.wreg, mem_if.wdata, bubble_cnt); end
    endtask

    task automatic test_flush();
        stall = 6'b001111;
        flush = 1'b1;
        tick();
        checks++; if (mem_if.wreg !== 1'b0 || mem_if.wdata !== 32'h0 || mem_if.wd !== 5'd0) begin errors++; $display("FAIL flush_nop: got wd=%0d wreg=%b wdata=%h want 0/0/0", mem_if.wd, mem_if.wreg, mem_if.wdata); end
        checks++; if (hilo_temp_o !== 64'h0 || cnt_o !== 2'd0 || bubble_cnt !== 16'd1) begin errors++; $display("FAIL flush_acc: got hilo=%h cnt=%0d bub=%0d want 0/0/1", hilo_temp_o, cnt_o, bubble_cnt); end
        flush = 1'b0;
        stall = '0;
        tick();
        stall = 6'b011111;
        flush = 1'b1;
        tick();
        checks++; if (mem_if.wreg !== 1'b0 || mem_if.wdata !== 32'h0) begin errors++; $display("FAIL flush_over_hold: got wreg=%b wdata=%h want 0/0", mem_if.wreg, mem_if.wdata); end
        flush = 1'b0;
        stall = '0;
    endtask

    task automatic test_hilo();
        ex_if.whilo = 1'b1;
        ex_if.hi = 32'hDEAD0000;
        ex_if.lo = 32'h0000BEEF;
        stall = 6'b100111;
        tick();
        checks++; if (mem_if.whilo !== 1'b1 || mem_if.hi !== 32'hDEAD0000 || mem_if.lo !== 32'h0000BEEF) begin errors++; $display("FAIL hilo_advance: got whilo=%b hi=%h lo=%h want 1/dead0000/0000beef", mem_if.whilo, mem_if.hi, mem_if.lo); end
        stall = 6'b001000;
        tick();
        checks++; if (mem_if.whilo !== 1'b0 || mem_if.hi !== 32'h0 || mem_if.lo !== 32'h0 || bubble_cnt !== 16'd2) begin errors++; $display("FAIL hilo_bubble: got whilo=%b hi=%h lo=%h bub=%0d want 0/0/0/2", mem_if.whilo, mem_if.hi, mem_if.lo, bubble_cnt); end
        stall = '0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_small [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        Rst_n = 1'b0;
        flush = 1'b1;
        stall = 6'b001111;
        tick();
        checks++; if (bubble_cnt !== 16'd0 || bubble_small !== 2'd0) begin errors++; $display("FAIL reset_over_flush: got bub=%0d small=%0d want 0/0", bubble_cnt, bubble_small); end
        Rst_n = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bubble_small !== exp_small[i] || bubble_cnt !== 16'(i + 1)) begin errors++; $display("FAIL sat_step%0d: got small=%0d wide=%0d want %0d/%0d", i, bubble_small, bubble_cnt, exp_small[i], i + 1); end
        end
        stall = '0;
        tick();
        checks++; if (bubble_small !== 2'd3 || bubble_cnt !== 16'd5) begin errors++; $display("FAIL sat_idle: got small=%0d wide=%0d want 3/5", bubble_small, bubble_cnt); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_bubble();
        test_flush();
        test_hilo();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_ctrl_reg.md
# ex_mem_ctrl_reg

Parametrised EX→MEM pipeline register with stall, flush and bubble handling, between the execute and memory-access stages. It carries the GPR write-back fields plus the HI/LO write, ALU opcode, memory address and store data. It also holds the multi-cycle accumulate state (madd/msub partial product and cycle counter) that EX loops back through this stage. A saturating counter records inserted bubbles for performance debug.

## Interface
Parameters:
- DATA_W, 32, datapath width (GPR, HI, LO, address)
- REG_ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU opcode width
- CNT_W, 2, multi-cycle op cycle-counter width
- STALL_W, 6, width of the global stall vector
- SRC_IDX, 3, stall bit owned by the upstream stage (EX)
- DST_IDX, 4, stall bit owned by the downstream stage (MEM)
- BUB_W, 16, bubble-counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- stall  in  STALL_W  global stall vector from the control unit
- flush  in  1  exception flush, kill the stage contents
- ex_wd / ex_wreg / ex_wdata  in  REG_ADDR_W / 1 / DATA_W  GPR write-back destination, enable and data
- ex_whilo / ex_hi / ex_lo  in  1 / DATA_W / DATA_W  HI/LO write enable and values
- ex_aluop / ex_mem_addr / ex_reg2  in  ALUOP_W / DATA_W / DATA_W  opcode, load/store address, store data
- hilo_temp_i / cnt_i  in  2*DATA_W / CNT_W  accumulate partial product and cycle count from EX
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  matching widths, registered copies
- hilo_temp_o / cnt_o  out  2*DATA_W / CNT_W  looped back to EX
- bubble_cnt  out  BUB_W  saturating count of inserted bubbles

## Operation
- Each rising edge takes exactly one action. Priority, highest first:
  1. Reset (Rst_n==0): all outputs go to zero. mem_wd=NOPRegAddr, mem_aluop=EXE_NOP_OP, bubble_cnt=0.
  2. Flush (flush==1): all mem_* take their reset values. hilo_temp_o=0, cnt_o=0. bubble_cnt holds.
  3. Bubble (stall[SRC_IDX]==1 and stall[DST_IDX]==0):
     - All mem_* take NOP values (wreg=0, whilo=0, aluop=EXE_NOP_OP, data/addr fields 0).
     - hilo_temp_o<=hilo_temp_i, cnt_o<=cnt_i.
     - bubble_cnt increments and saturates at all-ones.
  4. Advance (stall[SRC_IDX]==0): all mem_* load from the ex_* inputs. hilo_temp_o=0, cnt_o=0.
  5. Hold (both stall bits 1): every register keeps its value.
- A stall combination with the source bit 0 and the destination bit 1 is illegal. The block treats it as Advance. Verification asserts it never occurs.
- Only stall[SRC_IDX] and stall[DST_IDX] are observed. All other stall bits are ignored.

## Timing
- Latency is one cycle from ex_* to mem_* on Advance. There is no combinational path from input to output.
- hilo_temp_o and cnt_o become valid on the edge after the Bubble cycle, and EX sees them on the following cycle.
- Flush asserted together with any stall pattern: flush wins.
- Reset asserted together with flush: reset wins, and bubble_cnt clears.
- Reset mid multi-cycle op: the accumulate state is lost. EX restarts with cnt=0.
- bubble_cnt wraps never. At 2^BUB_W-1 it stays put.

## Structure
- The shared define header owns RstEnable, Stop, WriteDisable, ZeroWord, NOPRegAddr and EXE_NOP_OP, with their widths matching the parameter defaults.
- The bubble counter is a natural sub-module, sat_counter (parameter WIDTH; inputs clk, Rst_n, inc; output count). It is reusable for the other stage registers.
- The stage-register datapath stays inline. The next-state select is one priority if/else chain.

## Test plan
- Reset with ex_wreg=1, ex_wdata=0x12345678: all outputs 0, mem_aluop=EXE_NOP_OP. After release, with no stall, mem_wdata=0x12345678 one cycle later.
- Advance then Hold: load ex_wd=5, ex_wdata=0xA5A5A5A5, then stall=6'b011111 for 3 cycles with the inputs changed. Outputs stay at 5 / 0xA5A5A5A5.
- Bubble: stall=6'b001111, hilo_temp_i=0x0000_0001_FFFF_FFFE, cnt_i=1. Next cycle: mem_wreg=0, hilo_temp_o equals that value, cnt_o=1, bubble_cnt=1. When the stall drops, the next Advance clears hilo_temp_o and cnt_o to 0.
- Flush during Bubble: stall=6'b001111 and flush=1 together. mem_* are NOP, hilo_temp_o=0, cnt_o=0, bubble_cnt unchanged.
- Saturation with BUB_W=2: 5 consecutive Bubble cycles give bubble_cnt sequence 1,2,3,3,3.
- HI/LO path: ex_whilo=1, ex_hi=0xDEAD0000, ex_lo=0x0000BEEF with no stall. The outputs mirror those values after 1 cycle. A following Bubble drives mem_whilo=0.
